// File: rtl/fpage_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpage_arbiter
// Description : Two-requester round-robin arbiter feeding one forced-page
//               address register. Optional ack timeout: FPAGE_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fpage_arbiter #(
    parameter int unsigned            PAGE_BITS = 4,
    parameter logic [PAGE_BITS-1:0]   PAGE      = 4'hF,
    parameter int unsigned            TIMEOUT   = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0,
    input  logic [15:0] addr0,
    input  logic        force0,
    output logic        gnt0,
    input  logic        req1,
    input  logic [15:0] addr1,
    input  logic        force1,
    output logic        gnt1,
    output logic [15:0] out_addr,
    output logic        out_valid,
    output logic        out_owner,
`ifdef FPAGE_ARB_TIMEOUT_EN
    output logic        timeout_err,
`endif
    input  logic        out_ack
);

    localparam logic [15:0] c_LOW_MASK   = 16'hFFFF >> PAGE_BITS;
    localparam logic [15:0] c_PAGE_FIELD = 16'(PAGE) << (16 - PAGE_BITS);

    generate
        if (PAGE_BITS < 1 || PAGE_BITS > 16) begin : g_bad_page_bits
            $error("fpage_arbiter: PAGE_BITS must be 1..16");
        end
        if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
            $error("fpage_arbiter: TIMEOUT must be 2..255");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic [15:0] out_addr_q, out_addr_d;
    logic        out_valid_q, out_valid_d;
    logic        out_owner_q, out_owner_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;

    logic        win_sel;
    logic [15:0] win_addr;
    logic        win_force;

`ifdef FPAGE_ARB_TIMEOUT_EN
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]  cnt_q, cnt_d;
    logic        terr_q, terr_d;
`endif

    // Contention is settled by rr_ptr; a lone request always wins.
    always_comb begin
        win_sel   = (req0 && req1) ? rr_ptr_q : req1;
        win_addr  = win_sel ? addr1  : addr0;
        win_force = win_sel ? force1 : force0;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        out_owner_d = out_owner_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
`ifdef FPAGE_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        terr_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    out_addr_d  = win_force ? ((win_addr & c_LOW_MASK) | c_PAGE_FIELD)
                                            : win_addr;
                    out_owner_d = win_sel;
                    out_valid_d = 1'b1;
                    gnt0_d      = ~win_sel;
                    gnt1_d      = win_sel;
                    rr_ptr_d    = ~win_sel;
                    state_d     = S_ISSUE;
`ifdef FPAGE_ARB_TIMEOUT_EN
                    cnt_d       = 8'd0;
`endif
                end
            end
            S_ISSUE: begin
                if (out_ack) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
`ifdef FPAGE_ARB_TIMEOUT_EN
                else if (cnt_q == c_TO_LAST) begin
                    // Expiry leaves rr_ptr alone so the victim is not penalised.
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    terr_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 1'b0;
            out_addr_q  <= 16'h0000;
            out_valid_q <= 1'b0;
            out_owner_q <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
`ifdef FPAGE_ARB_TIMEOUT_EN
            cnt_q       <= 8'd0;
            terr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            out_owner_q <= out_owner_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
`ifdef FPAGE_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            terr_q      <= terr_d;
`endif
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign out_addr  = out_addr_q;
    assign out_valid = out_valid_q;
    assign out_owner = out_owner_q;
`ifdef FPAGE_ARB_TIMEOUT_EN
    assign timeout_err = terr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpage_arbiter.sv
`default_nettype none
// Testbench for fpage_arbiter: transaction-level reference model feeding a
// scoreboard queue, checked by an independent negedge monitor.
module tb_fpage_arbiter;

    localparam int unsigned TO = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        r_req [2];
    logic [15:0] r_addr[2];
    logic        r_frc [2];
    logic        out_ack;

    logic        gnt0, gnt1, out_valid, out_owner;
    logic [15:0] out_addr;
    logic        u2_gnt0, u2_gnt1, u2_valid, u2_owner;
    logic [15:0] u2_addr;
    logic        terr, u2_terr;

    always #5 CLK = ~CLK;

    fpage_arbiter #(.PAGE_BITS(4), .PAGE(4'hF), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .req0(r_req[0]), .addr0(r_addr[0]), .force0(r_frc[0]), .gnt0(gnt0),
        .req1(r_req[1]), .addr1(r_addr[1]), .force1(r_frc[1]), .gnt1(gnt1),
        .out_addr(out_addr), .out_valid(out_valid), .out_owner(out_owner),
`ifdef FPAGE_ARB_TIMEOUT_EN
        .timeout_err(terr),
`endif
        .out_ack(out_ack)
    );

    fpage_arbiter #(.PAGE_BITS(2), .PAGE(2'b10), .TIMEOUT(TO)) dut2 (
        .CLK(CLK), .RST(RST),
        .req0(r_req[0]), .addr0(r_addr[0]), .force0(r_frc[0]), .gnt0(u2_gnt0),
        .req1(r_req[1]), .addr1(r_addr[1]), .force1(r_frc[1]), .gnt1(u2_gnt1),
        .out_addr(u2_addr), .out_valid(u2_valid), .out_owner(u2_owner),
`ifdef FPAGE_ARB_TIMEOUT_EN
        .timeout_err(u2_terr),
`endif
        .out_ack(out_ack)
    );

`ifndef FPAGE_ARB_TIMEOUT_EN
    assign terr    = 1'b0;
    assign u2_terr = 1'b0;
`endif

    typedef struct {
        bit          owner;
        logic [15:0] addr;
        bit          frc;
        int          cyc;
    } item_t;

    item_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    // Reference model state
    bit    m_busy = 0;
    bit    m_rr = 0;
    int    m_cnt = 0;
    bit    exp_valid = 0;
    bit    exp_terr = 0;
    bit    gnew[2];
    bit    drop[2];

    function automatic logic [15:0] fpage(input logic [15:0] a, input bit f,
                                          input int pb, input logic [15:0] pg);
        logic [15:0] mask;
        mask = 16'hFFFF >> pb;
        return f ? ((pg << (16 - pb)) | (a & mask)) : a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit win;
        exp_terr = 0;
        if (m_busy) begin
            if (out_ack) m_busy = 0;
`ifdef FPAGE_ARB_TIMEOUT_EN
            else if (m_cnt + 1 >= int'(TO)) begin
                m_busy   = 0;
                exp_terr = 1;
            end else m_cnt++;
`endif
        end else if (r_req[0] || r_req[1]) begin
            win = (r_req[0] && r_req[1]) ? m_rr : 1'(r_req[1]);
            sb_q.push_back('{owner: win, addr: r_addr[win], frc: r_frc[win], cyc: cyc});
            m_rr      = !win;
            m_busy    = 1;
            m_cnt     = 0;
            gnew[win] = 1;
        end
        exp_valid = m_busy;
    endtask

    task automatic tick();
        @(posedge CLK);
        cyc++;
        if (RST) begin
            exp_valid = 0;
            exp_terr  = 0;
        end else model_step();
        #1;
    endtask

    // Monitor: independent of stimulus, pops on every new transfer
    bit          prev_valid = 0;
    item_t       cur;
    logic [15:0] hold_addr;
    bit          hold_owner;
    always @(negedge CLK) begin
        if (RST) begin
            prev_valid = 0;
        end else begin
            chk("out_valid", out_valid, exp_valid);
            chk("out_valid_p2", u2_valid, exp_valid);
            chk("timeout_err", terr, exp_terr);
            if (out_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_transfer", 1, 0);
                end else begin
                    cur = sb_q.pop_front();
                    hold_addr  = fpage(cur.addr, cur.frc, 4, 16'hF);
                    hold_owner = cur.owner;
                    chk("latency", cyc, cur.cyc);
                    chk("owner", out_owner, cur.owner);
                    chk("addr", out_addr, hold_addr);
                    chk("addr_page2", u2_addr, fpage(cur.addr, cur.frc, 2, 16'h2));
                    chk("gnt0", gnt0, !cur.owner);
                    chk("gnt1", gnt1, cur.owner);
                end
            end else begin
                chk("gnt0_quiet", gnt0, 0);
                chk("gnt1_quiet", gnt1, 0);
                if (out_valid) begin
                    chk("hold_addr", out_addr, hold_addr);
                    chk("hold_owner", out_owner, hold_owner);
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic xfer(input int r, input logic [15:0] a, input bit f, input int hold);
        r_addr[r] = a; r_frc[r] = f; r_req[r] = 1; out_ack = 0;
        tick();
        tick();
        r_req[r] = 0;
        repeat (hold) begin
            r_addr[1-r] = 16'($urandom);
            tick();
        end
        out_ack = 1;
        tick();
        out_ack = 0;
    endtask

    initial begin
        for (int r = 0; r < 2; r++) begin
            r_req[r] = 0; r_addr[r] = 16'h0; r_frc[r] = 0; gnew[r] = 0; drop[r] = 0;
        end
        out_ack = 0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_addr", out_addr, 16'h0);
        chk("rst_owner", out_owner, 0);
        chk("rst_gnt", {gnt1, gnt0}, 2'b00);
        tick();
        RST = 0;
        tick();

        // Directed single-requester transfers
        xfer(0, 16'h1234, 1, 2);
        xfer(0, 16'h1234, 0, 2);
        xfer(1, 16'hFFFF, 1, 0);
        xfer(0, 16'h5A5A, 1, 5);
        xfer(1, 16'h00C3, 0, 2);
`ifdef FPAGE_ARB_TIMEOUT_EN
        r_addr[0] = 16'h7777; r_frc[0] = 1; r_req[0] = 1;
        tick(); tick(); r_req[0] = 0;
        repeat (6) tick();
`endif

        // Asynchronous reset while a transfer is live
        r_addr[1] = 16'h4321; r_frc[1] = 1; r_req[1] = 1; out_ack = 0;
        tick(); tick(); r_req[1] = 0;
        #2 RST = 1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_gnt", {gnt1, gnt0}, 2'b00);
        chk("arst_addr", out_addr, 16'h0);
        chk("arst_owner", out_owner, 0);
        sb_q.delete();
        m_busy = 0; m_rr = 0; exp_valid = 0; exp_terr = 0;
        tick(); tick();
        RST = 0;

        // Contention with ack tied high: first winner must be requester 0
        r_addr[0] = 16'h0AAA; r_addr[1] = 16'h0555; r_frc[0] = 1; r_frc[1] = 1;
        r_req[0] = 1; r_req[1] = 1; out_ack = 1;
        repeat (12) tick();
        r_req[0] = 0; r_req[1] = 0;
        tick(); tick();
        out_ack = 0;

        // Randomised requesters obeying the request protocol
        for (int r = 0; r < 2; r++) begin gnew[r] = 0; drop[r] = 0; end
        repeat (600) begin
            tick();
            out_ack = ($urandom_range(0, 2) == 0);
            for (int r = 0; r < 2; r++) begin
                if (drop[r]) begin
                    r_req[r] = 0; drop[r] = 0;
                end else if (gnew[r]) begin
                    drop[r] = 1; gnew[r] = 0;
                end else if (!r_req[r]) begin
                    r_addr[r] = 16'($urandom);
                    r_frc[r]  = 1'($urandom);
                    r_req[r]  = ($urandom_range(0, 2) == 0);
                end
            end
        end
        r_req[0] = 0; r_req[1] = 0; out_ack = 1;
        repeat (4) tick();
        out_ack = 0;
        tick();
        #6;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
